// File: rtl/calc_port_responder_if.sv
// Request/response bundle for the calc port: the requester drives the command and operands,
// the responder returns the response code, result, busy flag and error count.
interface calc_port_responder_if #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned CMD_W    = 4,
  parameter int unsigned ERRCNT_W = 8
);
  logic [CMD_W-1:0]    req_cmd_in;
  logic [DATA_W-1:0]   req_data_in;
  logic [1:0]          out_resp;
  logic [DATA_W-1:0]   out_data;
  logic                busy;
  logic [ERRCNT_W-1:0] err_count;

  modport master (
    output req_cmd_in, req_data_in,
    input  out_resp, out_data, busy, err_count
  );

  modport slave (
    input  req_cmd_in, req_data_in,
    output out_resp, out_data, busy, err_count
  );
endinterface

// File: rtl/calc_port_responder.sv
// Calc port responder: two-cycle request (cmd+op1, then op2), one-cycle registered response.
// Supports add, subtract, shift-left and shift-right; counts error responses with saturation.
module calc_port_responder #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned CMD_W    = 4,
  parameter int unsigned ERRCNT_W = 8
) (
  input  logic                         c_clk,
  input  logic                         reset,
  calc_port_responder_if.slave         bus
);

  typedef enum logic [1:0] {StIdle, StOp2, StExec} state_e;

  localparam logic [CMD_W-1:0] CmdAdd = CMD_W'(1);
  localparam logic [CMD_W-1:0] CmdSub = CMD_W'(2);
  localparam logic [CMD_W-1:0] CmdShl = CMD_W'(5);
  localparam logic [CMD_W-1:0] CmdShr = CMD_W'(6);

  localparam logic [1:0] RespNone = 2'd0;
  localparam logic [1:0] RespOk   = 2'd1;
  localparam logic [1:0] RespErr  = 2'd2;

  state_e              state_q, state_d;
  logic [CMD_W-1:0]    cmd_q, cmd_d;
  logic [DATA_W-1:0]   op1_q, op1_d;
  logic [DATA_W-1:0]   op2_q, op2_d;
  logic [1:0]          resp_q, resp_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ERRCNT_W-1:0] err_q, err_d;

  logic [DATA_W:0]     sum;
  logic [4:0]          shamt;

  assign sum   = {1'b0, op1_q} + {1'b0, op2_q};
  assign shamt = op2_q[4:0];

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    resp_d  = RespNone;
    data_d  = '0;
    err_d   = err_q;

    case (state_q)
      StIdle: begin
        if (bus.req_cmd_in != '0) begin
          cmd_d   = bus.req_cmd_in;
          op1_d   = bus.req_data_in;
          state_d = StOp2;
        end
      end
      StOp2: begin
        op2_d   = bus.req_data_in;
        state_d = StExec;
      end
      StExec: begin
        case (cmd_q)
          CmdAdd: begin
            if (sum[DATA_W]) begin
              resp_d = RespErr;
            end else begin
              resp_d = RespOk;
              data_d = sum[DATA_W-1:0];
            end
          end
          CmdSub: begin
            if (op2_q > op1_q) begin
              resp_d = RespErr;
            end else begin
              resp_d = RespOk;
              data_d = op1_q - op2_q;
            end
          end
          CmdShl: begin
            resp_d = RespOk;
            data_d = op1_q << shamt;
          end
          CmdShr: begin
            resp_d = RespOk;
            data_d = op1_q >> shamt;
          end
          default: resp_d = RespErr;
        endcase

        // A command presented during EXEC starts the next request immediately.
        if (bus.req_cmd_in != '0) begin
          cmd_d   = bus.req_cmd_in;
          op1_d   = bus.req_data_in;
          state_d = StOp2;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (resp_d == RespErr && err_q != '1) begin
      err_d = err_q + ERRCNT_W'(1);
    end
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cmd_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      resp_q  <= RespNone;
      data_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      resp_q  <= resp_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign bus.out_resp  = resp_q;
  assign bus.out_data  = data_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.err_count = err_q;

endmodule

// File: tb/tb_calc_port_responder.sv
// Directed bench for calc_port_responder: hand-computed vectors checked with immediate assertions.
module tb_calc_port_responder;

  logic c_clk;
  logic reset;
  int   n_vec;
  int   n_err;
  int   exp_err;

  calc_port_responder_if bus ();

  calc_port_responder dut (
    .c_clk (c_clk),
    .reset (reset),
    .bus   (bus)
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  task automatic step();
    @(posedge c_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request from IDLE and check the response window E+1..E+3.
  task automatic do_req(input string tag, input logic [3:0] cmd, input logic [31:0] op1,
                        input logic [31:0] op2, input logic [1:0] er, input logic [31:0] ed);
    bus.req_cmd_in  = cmd;
    bus.req_data_in = op1;
    step();
    bus.req_cmd_in  = 4'd0;
    bus.req_data_in = op2;
    step();
    check({tag, "_pre"}, 32'(bus.out_resp), 32'd0);
    bus.req_data_in = 32'd0;
    step();
    if (er == 2'd2 && exp_err != 255) exp_err++;
    check({tag, "_resp"}, 32'(bus.out_resp), 32'(er));
    check({tag, "_data"}, bus.out_data, ed);
    check({tag, "_errcnt"}, 32'(bus.err_count), 32'(exp_err));
    step();
    check({tag, "_post"}, 32'(bus.out_resp), 32'd0);
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    exp_err = 0;
    reset           = 1'b0;
    bus.req_cmd_in  = 4'd1;
    bus.req_data_in = 32'd5;

    repeat (4) step();
    check("rst_resp", 32'(bus.out_resp), 32'd0);
    check("rst_data", bus.out_data, 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_errcnt", 32'(bus.err_count), 32'd0);

    reset = 1'b1;
    step();  // E: first command sample
    check("rel_busy", 32'(bus.busy), 32'd1);
    check("rel_resp_e0", 32'(bus.out_resp), 32'd0);
    bus.req_cmd_in = 4'd0;
    step();  // E+1
    check("rel_resp_e1", 32'(bus.out_resp), 32'd0);
    step();  // E+2
    check("rel_resp_e2", 32'(bus.out_resp), 32'd1);
    check("rel_data_e2", bus.out_data, 32'd10);
    step();  // E+3
    check("rel_resp_e3", 32'(bus.out_resp), 32'd0);
    check("rel_busy_e3", 32'(bus.busy), 32'd0);

    do_req("add_a", 4'd1, 32'h0000_0001, 32'h1FFF_FFFF, 2'd1, 32'h2000_0000);
    do_req("add_b", 4'd1, 32'h1FFF_FFFF, 32'h1FFF_FFFF, 2'd1, 32'h3FFF_FFFE);
    do_req("add_ovf", 4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'd0);
    do_req("sub_unf", 4'd2, 32'h0000_0001, 32'h0000_000F, 2'd2, 32'd0);
    do_req("cmd3", 4'd3, 32'h0000_0001, 32'h0000_0001, 2'd2, 32'd0);
    do_req("cmd4", 4'd4, 32'h0000_0001, 32'h0000_0001, 2'd2, 32'd0);

    bus.req_cmd_in  = 4'd0;
    bus.req_data_in = 32'h1234_5678;
    repeat (4) begin
      step();
      check("cmd0_resp", 32'(bus.out_resp), 32'd0);
      check("cmd0_busy", 32'(bus.busy), 32'd0);
    end

    for (int k = 0; k <= 30; k++) begin
      do_req("shl_k", 4'd5, 32'd1 << k, 32'd1, 2'd1, 32'd1 << (k + 1));
    end
    do_req("shl_amt", 4'd5, 32'h0000_0001, 32'h0000_0021, 2'd1, 32'd2);
    do_req("shr31", 4'd6, 32'h8000_0000, 32'd31, 2'd1, 32'd1);

    // Back-to-back: 2+3, then 7-4 issued in the add's EXEC cycle.
    bus.req_cmd_in  = 4'd1;
    bus.req_data_in = 32'd2;
    step();
    bus.req_cmd_in  = 4'd0;
    bus.req_data_in = 32'd3;
    step();
    bus.req_cmd_in  = 4'd2;
    bus.req_data_in = 32'd7;
    step();
    check("b2b_resp1", 32'(bus.out_resp), 32'd1);
    check("b2b_data1", bus.out_data, 32'd5);
    check("b2b_busy", 32'(bus.busy), 32'd1);
    bus.req_cmd_in  = 4'd0;
    bus.req_data_in = 32'd4;
    step();
    check("b2b_gap", 32'(bus.out_resp), 32'd0);
    step();
    check("b2b_resp2", 32'(bus.out_resp), 32'd1);
    check("b2b_data2", bus.out_data, 32'd3);
    step();
    check("b2b_post", 32'(bus.out_resp), 32'd0);

    // Abort in OP2.
    bus.req_cmd_in  = 4'd1;
    bus.req_data_in = 32'd1;
    step();
    check("abort_busy_op2", 32'(bus.busy), 32'd1);
    bus.req_cmd_in = 4'd0;
    #2 reset = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_resp", 32'(bus.out_resp), 32'd0);
    step();
    reset   = 1'b1;
    exp_err = 0;
    repeat (3) begin
      step();
      check("abort_noresp", 32'(bus.out_resp), 32'd0);
      check("abort_idle", 32'(bus.busy), 32'd0);
    end
    check("abort_errcnt", 32'(bus.err_count), 32'd0);

    // Saturation: 255 errors, then one more.
    for (int i = 0; i < 255; i++) begin
      bus.req_cmd_in = 4'd3;
      step();
      bus.req_cmd_in = 4'd0;
      step();
      step();
    end
    exp_err = 255;
    check("sat_255", 32'(bus.err_count), 32'd255);
    do_req("sat_more", 4'd3, 32'd1, 32'd1, 2'd2, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
